// File: rtl/vga_fb_reader_pkg.sv
// Shared constants and helpers for the 160x120 frame-buffer VGA reader.
// Holds default 640x480@60 timing, buffer geometry and colour expansion.
package vga_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_ADDR_W = 15;

    localparam int CNT_W = 10;
    localparam int DAC_W = 10;

    function automatic int colour_w(input int bpc);
        return 3 * bpc;
    endfunction

    // Replicates the low bpc bits of v, MSB first, until DAC_W bits are filled.
    function automatic logic [DAC_W-1:0] expand_chan(input logic [DAC_W-1:0] v, input int bpc);
        logic [DAC_W-1:0] r;
        r = '0;
        for (int i = 0; i < DAC_W; i++) begin
            r = (r << 1) | ((v >> (bpc - 1 - (i % bpc))) & DAC_W'(1));
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// Frame-buffer read port: registered-address request, data one CLOCK_50 later.
interface vga_fb_reader_if #(
    parameter int BPC = 1
);
    import vga_pkg::*;

    logic [FB_ADDR_W-1:0]     rd_addr;
    logic [colour_w(BPC)-1:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);

endinterface

// File: rtl/vga_fb_reader_timing_gen.sv
// Pixel tick, raster counters and raw sync/visible flags for the VGA reader.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             o_pix_en,
    output logic             o_pix_clk,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_vis
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic             r_tog;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tog  <= 1'b0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_tog <= ~r_tog;
            if (r_tog) begin
                if (r_hcnt == CNT_W'(H_TOTAL - 1)) begin
                    r_hcnt <= '0;
                    if (r_vcnt == CNT_W'(V_TOTAL - 1)) begin
                        r_vcnt <= '0;
                    end else begin
                        r_vcnt <= r_vcnt + CNT_W'(1);
                    end
                end else begin
                    r_hcnt <= r_hcnt + CNT_W'(1);
                end
            end
        end
    end

    // Toggle high means the coming edge is a pixel edge; the DAC clock is its inverse.
    assign o_pix_en  = r_tog;
    assign o_pix_clk = ~r_tog;
    assign o_hcnt    = r_hcnt;
    assign o_vcnt    = r_vcnt;

    assign o_vis = (r_hcnt < CNT_W'(H_VIS)) && (r_vcnt < CNT_W'(V_VIS));
    assign o_hs  = !((r_hcnt >= CNT_W'(H_VIS + H_FP)) &&
                     (r_hcnt <  CNT_W'(H_VIS + H_FP + H_SYNC)));
    assign o_vs  = !((r_vcnt >= CNT_W'(V_VIS + V_FP)) &&
                     (r_vcnt <  CNT_W'(V_VIS + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_fb_reader.sv
// Scans a 160x120 frame buffer as 640x480@60 VGA with 4x4 pixel blocks.
// Optional colour-bar source selected by pattern_sel: VGA_FB_READER_TEST_PATTERN_EN.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int BITS_PER_COLOUR_CHANNEL = 1,
    parameter int H_VIS     = VGA_H_VIS,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VIS     = VGA_V_VIS,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int RES_SHIFT = 2
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    vga_fb_reader_if.master   fb,
    input  logic              pattern_sel,
    output logic [DAC_W-1:0]  VGA_R,
    output logic [DAC_W-1:0]  VGA_G,
    output logic [DAC_W-1:0]  VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic              VGA_CLK
);

    localparam int BPC = BITS_PER_COLOUR_CHANNEL;

    logic             w_pix_en;
    logic             w_pix_clk;
    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_hs;
    logic             w_vs;
    logic             w_vis;

    vga_timing_gen #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk       (CLOCK_50),
        .resetn    (resetn),
        .o_pix_en  (w_pix_en),
        .o_pix_clk (w_pix_clk),
        .o_hcnt    (w_hcnt),
        .o_vcnt    (w_vcnt),
        .o_hs      (w_hs),
        .o_vs      (w_vs),
        .o_vis     (w_vis)
    );

    // Buffer row stride of 160 built as 128 + 32 to avoid a multiplier.
    logic [FB_ADDR_W-1:0] w_yb;
    logic [FB_ADDR_W-1:0] w_xb;
    logic [FB_ADDR_W-1:0] w_addr;

    assign w_yb   = FB_ADDR_W'(w_vcnt >> RES_SHIFT);
    assign w_xb   = FB_ADDR_W'(w_hcnt >> RES_SHIFT);
    assign w_addr = (w_yb << 7) + (w_yb << 5) + w_xb;

    logic [FB_ADDR_W-1:0] r_rd_addr;
    logic                 r_vis1;
    logic                 r_hs1;
    logic                 r_vs1;
    logic [DAC_W-1:0]     r_vga_r;
    logic [DAC_W-1:0]     r_vga_g;
    logic [DAC_W-1:0]     r_vga_b;
    logic                 r_hs2;
    logic                 r_vs2;
    logic                 r_blank2;

    logic [2:0][DAC_W-1:0] w_chan;

`ifdef VGA_FB_READER_TEST_PATTERN_EN
    logic [2:0] r_pat1;

    // Bar colour follows the pixel through stage 1 so it lines up with RAM data.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_pat1 <= '0;
        end else if (w_pix_en) begin
            r_pat1 <= w_hcnt[CNT_W-1 -: 3];
        end
    end
`else
    logic w_unused_pattern_sel;
    assign w_unused_pattern_sel = pattern_sel;
`endif

    // Channel 0 is R (top of rd_data), 1 is G, 2 is B.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [DAC_W-1:0] w_ram_chan;
        assign w_ram_chan = DAC_W'(fb.rd_data[(3 - gi) * BPC - 1 -: BPC]);
`ifdef VGA_FB_READER_TEST_PATTERN_EN
        assign w_chan[gi] = pattern_sel ? expand_chan(DAC_W'(r_pat1[2 - gi]), 1)
                                        : expand_chan(w_ram_chan, BPC);
`else
        assign w_chan[gi] = expand_chan(w_ram_chan, BPC);
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_rd_addr <= '0;
            r_vis1    <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_vga_r   <= '0;
            r_vga_g   <= '0;
            r_vga_b   <= '0;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_blank2  <= 1'b0;
        end else if (w_pix_en) begin
            r_rd_addr <= w_vis ? w_addr : '0;
            r_vis1    <= w_vis;
            r_hs1     <= w_hs;
            r_vs1     <= w_vs;
            // RAM data for the stage-1 address landed on the mid-period edge.
            r_vga_r   <= r_vis1 ? w_chan[0] : '0;
            r_vga_g   <= r_vis1 ? w_chan[1] : '0;
            r_vga_b   <= r_vis1 ? w_chan[2] : '0;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_blank2  <= r_vis1;
        end
    end

    assign fb.rd_addr  = r_rd_addr;
    assign VGA_R       = r_vga_r;
    assign VGA_G       = r_vga_g;
    assign VGA_B       = r_vga_b;
    assign VGA_HS      = r_hs2;
    assign VGA_VS      = r_vs2;
    assign VGA_BLANK_N = r_blank2;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_CLK     = w_pix_clk;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: full-frame DUT plus a short-frame DUT, random RAM contents,
// raster-position model computed from the elapsed pixel-tick count.
module tb_vga_fb_reader;

    localparam int HT = 800;
    localparam int SV_VIS = 8, SV_FP = 2, SV_SYNC = 2, SV_BP = 2;
    localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;

    typedef struct packed {
        logic [14:0] addr;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        sync_n;
        logic        vclk;
    } pins_t;

    logic CLOCK_50 = 1'b0;
    logic resetn = 1'b0;
    logic pattern_sel = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_fb_reader_if #(.BPC(1)) fb_a ();
    vga_fb_reader_if #(.BPC(1)) fb_b ();

    logic [9:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic hs_a, vs_a, blank_a, syncn_a, vclk_a;
    logic hs_b, vs_b, blank_b, syncn_b, vclk_b;

    vga_fb_reader #(.BITS_PER_COLOUR_CHANNEL(1)) dut_a (
        .CLOCK_50 (CLOCK_50), .resetn (resetn), .fb (fb_a), .pattern_sel (pattern_sel),
        .VGA_R (r_a), .VGA_G (g_a), .VGA_B (b_a), .VGA_HS (hs_a), .VGA_VS (vs_a),
        .VGA_BLANK_N (blank_a), .VGA_SYNC_N (syncn_a), .VGA_CLK (vclk_a)
    );

    vga_fb_reader #(
        .BITS_PER_COLOUR_CHANNEL(1),
        .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut_b (
        .CLOCK_50 (CLOCK_50), .resetn (resetn), .fb (fb_b), .pattern_sel (pattern_sel),
        .VGA_R (r_b), .VGA_G (g_b), .VGA_B (b_b), .VGA_HS (hs_b), .VGA_VS (vs_b),
        .VGA_BLANK_N (blank_b), .VGA_SYNC_N (syncn_b), .VGA_CLK (vclk_b)
    );

    logic [2:0] mem [32768];

    always @(posedge CLOCK_50) begin
        fb_a.rd_data <= mem[fb_a.rd_addr];
        fb_b.rd_data <= mem[fb_b.rd_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] colour(input int h, input int v, input logic ps);
        if (ps) return 3'((h / 128) % 8);
        return mem[(v / 4) * 160 + h / 4];
    endfunction

    // e = CLOCK_50 edges since reset release; pixel ticks happen on even edges.
    function automatic pins_t model(input int e, input int vvis, input int vss,
                                    input int vtot, input logic ps);
        pins_t p;
        int k, pos, h, v;
        logic [2:0] c;
        k = e / 2;
        p = '0;
        p.hs = 1'b1;
        p.vs = 1'b1;
        p.sync_n = 1'b1;
        p.vclk = (e % 2 == 0);
        if (k >= 1) begin
            pos = (k - 1) % (HT * vtot);
            h = pos % HT;
            v = pos / HT;
            if (h < 640 && v < vvis) p.addr = 15'((v / 4) * 160 + h / 4);
        end
        if (k >= 2) begin
            pos = (k - 2) % (HT * vtot);
            h = pos % HT;
            v = pos / HT;
            p.blank = (h < 640 && v < vvis);
            p.hs = !(h >= 656 && h < 752);
            p.vs = !(v >= vss && v < vss + 2);
            if (p.blank) begin
                c = colour(h, v, ps);
                p.r = {10{c[2]}};
                p.g = {10{c[1]}};
                p.b = {10{c[0]}};
            end
        end
        return p;
    endfunction

    int e = 0;
    int k, h1, v1, h2, v2;
    int hs_fall = 0, blank_rise = 0, vs_fall = -1, vs_low = 0;
    logic prev_hs = 1'b1, prev_blank = 1'b0, prev_vs = 1'b1;
    logic ps_eff = 1'b0;
    pins_t act_a, act_b;

    always @(posedge CLOCK_50) begin
        if (!resetn) e = 0;
        else e = e + 1;
`ifdef VGA_FB_READER_TEST_PATTERN_EN
        if (e % 2 == 0) ps_eff = pattern_sel;
`endif
        #1;
        act_a = {fb_a.rd_addr, r_a, g_a, b_a, hs_a, vs_a, blank_a, syncn_a, vclk_a};
        act_b = {fb_b.rd_addr, r_b, g_b, b_b, hs_b, vs_b, blank_b, syncn_b, vclk_b};
        chk("pins_full_frame", 64'(act_a), 64'(model(e, 480, 490, 525, ps_eff)));
        chk("pins_short_frame", 64'(act_b), 64'(model(e, SV_VIS, SV_VIS + SV_FP, SV_TOT, ps_eff)));

        k = e / 2;
        if (e == 0) begin
            prev_hs = 1'b1;
            prev_blank = 1'b0;
            prev_vs = 1'b1;
            vs_fall = -1;
        end else if (e % 2 == 0) begin
            if (prev_hs && !hs_a) begin
                chk("hs_fall_tick", 64'(k % HT), 64'(658));
                hs_fall = k;
            end
            if (!prev_hs && hs_a) chk("hs_low_ticks", 64'(k - hs_fall), 64'(96));
            if (!prev_blank && blank_a) begin
                chk("blank_rise_tick", 64'(k % HT), 64'(2));
                blank_rise = k;
            end
            if (prev_blank && !blank_a) chk("blank_high_ticks", 64'(k - blank_rise), 64'(640));
            if (prev_vs && !vs_b) begin
                chk("vs_fall_tick", 64'(k % (HT * SV_TOT)), 64'(8002));
                if (vs_fall >= 0) chk("frame_ticks", 64'(k - vs_fall), 64'(11200));
                vs_fall = k;
                vs_low = k;
            end
            if (!prev_vs && vs_b) chk("vs_low_ticks", 64'(k - vs_low), 64'(1600));
            prev_hs = hs_a;
            prev_blank = blank_a;
            prev_vs = vs_b;

            h1 = (k - 1) % HT;
            v1 = (k - 1) / HT;
            if (v1 == 5 && h1 >= 4 && h1 < 8) chk("addr_y5_x4to7", 64'(fb_a.rd_addr), 64'(161));
            if (v1 == 5 && h1 == 639) chk("addr_y5_h639", 64'(fb_a.rd_addr), 64'(319));
            if (v1 == 5 && h1 == 640) chk("addr_y5_h640", 64'(fb_a.rd_addr), 64'(0));
            if (k >= 2) begin
                h2 = (k - 2) % HT;
                v2 = (k - 2) / HT;
                if (v2 == 5 && h2 >= 4 && h2 < 8 && !ps_eff)
                    chk("rgb_101", {34'd0, r_a, g_a, b_a}, {34'd0, 10'h3FF, 10'h000, 10'h3FF});
`ifdef VGA_FB_READER_TEST_PATTERN_EN
                if (v2 == 9 && h2 == 128 && ps_eff)
                    chk("pattern_h128", {34'd0, r_a, g_a, b_a}, {34'd0, 10'h000, 10'h000, 10'h3FF});
`endif
            end
            if (k > 0 && k % HT == 0)
                $display("line %0d scanned: checks %0d errors %0d", k / HT - 1, checks, errors);
        end
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
        mem[161] = 3'b101;
        resetn = 1'b0;
        pattern_sel = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        chk("reset_addr", 64'(fb_a.rd_addr), 64'(0));
        chk("reset_rgb", {34'd0, r_a, g_a, b_a}, 64'(0));
        chk("reset_ctrl", {59'd0, hs_a, vs_a, blank_a, syncn_a, vclk_a}, {59'd0, 5'b11011});
        resetn = 1'b1;
        @(posedge CLOCK_50);
        #1 chk("vclk_edge1", 64'(vclk_a), 64'(0));
        @(posedge CLOCK_50);
        #1 chk("vclk_edge2", 64'(vclk_a), 64'(1));
        repeat (2 * 8 * HT - 1) @(negedge CLOCK_50);
        for (int ln = 8; ln < 28; ln++) begin
            pattern_sel = (ln == 9) ? 1'b1 : 1'($urandom_range(0, 1));
            repeat (2 * HT) @(negedge CLOCK_50);
        end
        pattern_sel = 1'b0;
        // Reset lands with the counters at hcnt=300 of line 28.
        repeat (600) @(negedge CLOCK_50);
        resetn = 1'b0;
        @(posedge CLOCK_50);
        #2;
        chk("midframe_reset_addr", 64'(fb_a.rd_addr), 64'(0));
        chk("midframe_reset_rgb", {34'd0, r_a, g_a, b_a}, 64'(0));
        chk("midframe_reset_ctrl", {59'd0, hs_a, vs_a, blank_a, syncn_a, vclk_a}, {59'd0, 5'b11011});
        chk("midframe_reset_short", 64'(fb_b.rd_addr), 64'(0));
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (2 * 2 * HT) @(negedge CLOCK_50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
